// File: rtl/level_meter_pkg.sv
// Shared level-meter types: FSM encoding, percent range, default calibration points.
// Pure declarations; no latency or flow control of its own.
// Imported by the calibrator, its bus interface and the display path.
package level_meter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    CHECK,
    SETUP,
    DIV,
    DONE
  } calState_t;

  localparam int PCT_W   = 7;
  localparam int PCT_MAX = 100;
  localparam int CAL_LOW = 0;

  // Default high point is full scale for the given sample width.
  function automatic int defaultCalHigh(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/level_calibrator_if.sv
// Bus between the debouncer/ADC sampler side and the level calibrator.
// Wires only; strobes are single-cycle with no backpressure.
// master drives buttons and samples, slave is the calibrator.
interface level_calibrator_if #(
  parameter int W = 12
);
  import level_meter_pkg::*;

  logic             sample_valid;
  logic [W-1:0]     sample;
  logic             reset_button_out;
  logic             saveH_button_out;
  logic             saveL_button_out;
  logic [PCT_W-1:0] level_pct;
  logic             level_valid;
  logic [W-1:0]     cal_low;
  logic [W-1:0]     cal_high;
  logic             cal_ok;
  logic             busy;

  modport master (
    output sample_valid, sample, reset_button_out, saveH_button_out, saveL_button_out,
    input  level_pct, level_valid, cal_low, cal_high, cal_ok, busy
  );

  modport slave (
    input  sample_valid, sample, reset_button_out, saveH_button_out, saveL_button_out,
    output level_pct, level_valid, cal_low, cal_high, cal_ok, busy
  );

endinterface

// File: rtl/level_calibrator_seq_divider.sv
// Restoring divider, one quotient bit per cycle: quot = num / den, truncated.
// done pulses NW cycles after start (first bit is resolved in the start cycle).
// No backpressure; a new start restarts and discards any division in flight.
module seq_divider #(
  parameter int NW = 19,
  parameter int DW = 12
) (
  input  logic          clk_100MHz,
  input  logic          reset,
  input  logic          start,
  input  logic [NW-1:0] num,
  input  logic [DW-1:0] den,
  output logic          done,
  output logic [NW-1:0] quot
);

  localparam int CW = $clog2(NW + 1);

  logic [DW-1:0] rem, remIn, stepRem;
  logic [NW-1:0] q, qIn, stepQ;
  logic [DW-1:0] d, dIn;
  logic [DW:0]   shifted, diff;
  logic [CW-1:0] cnt;

  // One restoring step, applied to fresh operands on start or to the running state.
  always_comb begin
    remIn   = start ? '0  : rem;
    qIn     = start ? num : q;
    dIn     = start ? den : d;
    shifted = {remIn, qIn[NW-1]};
    diff    = shifted - {1'b0, dIn};
    if (shifted >= {1'b0, dIn}) begin
      stepRem = diff[DW-1:0];
      stepQ   = {qIn[NW-2:0], 1'b1};
    end else begin
      stepRem = shifted[DW-1:0];
      stepQ   = {qIn[NW-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      rem  <= '0;
      q    <= '0;
      d    <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem  <= stepRem;
        q    <= stepQ;
        d    <= den;
        cnt  <= CW'(NW - 1);
        done <= (NW == 1);
      end else if (cnt != '0) begin
        rem <= stepRem;
        q   <= stepQ;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) done <= 1'b1;
      end
    end
  end

  assign quot = q;

endmodule

// File: rtl/level_calibrator.sv
// Stores low/high calibration points and maps each raw sample to 0..100 % (LEVEL_CAL_AVG_EN averages captures).
// level_valid fires W+9 cycles after the accepted sample_valid, clamped cases included.
// No backpressure: samples outside IDLE are dropped; button pulses while busy are held as pending.
module level_calibrator
  import level_meter_pkg::*;
#(
  parameter int W        = 12,
  parameter int MIN_SPAN = 16,
  parameter int AVG_LOG2 = 3
) (
  input  logic            clk_100MHz,
  input  logic            reset,
  level_calibrator_if.slave bus
);

  localparam int NW = W + 7;

  calState_t state, nextState;

  logic             rstPrev, hPrev, lPrev;
  logic             rstEdge, hEdge, lEdge;
  logic             takeH, takeL;
  logic             pendH, pendL, capHigh;
  logic [W-1:0]     sampleReg, calLow, calHigh, sClamp;
  logic             calOk, levelValid;
  logic [PCT_W-1:0] levelPct;
  logic             capDone;
  logic [W-1:0]     capValue;
  logic             divStart, divDone;
  logic [NW-1:0]    divNum, divQuot;
  logic [W-1:0]     divDen;

  assign rstEdge = bus.reset_button_out & ~rstPrev;
  assign hEdge   = bus.saveH_button_out & ~hPrev;
  assign lEdge   = bus.saveL_button_out & ~lPrev;
  assign takeH   = hEdge | pendH;
  assign takeL   = lEdge | pendL;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (takeH || takeL)                    nextState = CAPTURE;
               else if (bus.sample_valid && calOk)    nextState = SETUP;
      CAPTURE: if (capDone)                           nextState = CHECK;
      CHECK:                                          nextState = IDLE;
      SETUP:                                          nextState = DIV;
      DIV:     if (divDone)                           nextState = DONE;
      DONE:                                           nextState = IDLE;
      default:                                        nextState = IDLE;
    endcase
    if (rstEdge) nextState = IDLE;
  end

`ifdef LEVEL_CAL_AVG_EN
  localparam int SUM_W = W + AVG_LOG2;
  logic [SUM_W-1:0]    capSum, capSumNext;
  logic [AVG_LOG2-1:0] capCnt;

  assign capSumNext = capSum + SUM_W'(bus.sample);
  assign capDone    = (state == CAPTURE) && bus.sample_valid && (capCnt == '1);
  assign capValue   = capSumNext[SUM_W-1:AVG_LOG2];

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      capSum <= '0;
      capCnt <= '0;
    end else if (state != CAPTURE) begin
      capSum <= '0;
      capCnt <= '0;
    end else if (bus.sample_valid) begin
      capSum <= capSumNext;
      capCnt <= capCnt + AVG_LOG2'(1);
    end
  end
`else
  assign capDone  = (state == CAPTURE) && bus.sample_valid;
  assign capValue = bus.sample;
`endif

  always_comb begin
    sClamp = sampleReg;
    if (sampleReg < calLow)       sClamp = calLow;
    else if (sampleReg > calHigh) sClamp = calHigh;
  end

  assign divNum   = NW'(sClamp - calLow) * NW'(PCT_MAX);
  assign divDen   = calHigh - calLow;
  assign divStart = (state == SETUP) && !rstEdge;

  seq_divider #(.NW(NW), .DW(W)) uDiv (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .start      (divStart),
    .num        (divNum),
    .den        (divDen),
    .done       (divDone),
    .quot       (divQuot)
  );

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      rstPrev    <= 1'b0;
      hPrev      <= 1'b0;
      lPrev      <= 1'b0;
      pendH      <= 1'b0;
      pendL      <= 1'b0;
      capHigh    <= 1'b0;
      sampleReg  <= '0;
      calLow     <= W'(CAL_LOW);
      calHigh    <= W'(defaultCalHigh(W));
      calOk      <= 1'b1;
      levelPct   <= '0;
      levelValid <= 1'b0;
    end else begin
      rstPrev    <= bus.reset_button_out;
      hPrev      <= bus.saveH_button_out;
      lPrev      <= bus.saveL_button_out;
      levelValid <= 1'b0;
      if (rstEdge) begin
        calLow  <= W'(CAL_LOW);
        calHigh <= W'(defaultCalHigh(W));
        calOk   <= 1'b1;
        pendH   <= 1'b0;
        pendL   <= 1'b0;
      end else begin
        if (state == IDLE) begin
          // High wins over low; a simultaneous low request is parked for the next pass.
          if (takeH) begin
            capHigh <= 1'b1;
            pendH   <= 1'b0;
            pendL   <= pendL | lEdge;
          end else if (takeL) begin
            capHigh <= 1'b0;
            pendL   <= 1'b0;
          end else if (bus.sample_valid && calOk) begin
            sampleReg <= bus.sample;
          end
        end else begin
          pendH <= pendH | hEdge;
          pendL <= pendL | lEdge;
        end
        if (capDone) begin
          if (capHigh) calHigh <= capValue;
          else         calLow  <= capValue;
        end
        if (state == CHECK)
          calOk <= ({1'b0, calHigh} > ({1'b0, calLow} + (W + 1)'(MIN_SPAN)));
        if (state == DIV && divDone) begin
          levelPct   <= (divQuot > NW'(PCT_MAX)) ? PCT_W'(PCT_MAX) : divQuot[PCT_W-1:0];
          levelValid <= 1'b1;
        end
      end
    end
  end

  assign bus.level_pct   = levelPct;
  assign bus.level_valid = levelValid;
  assign bus.cal_low     = calLow;
  assign bus.cal_high    = calHigh;
  assign bus.cal_ok      = calOk;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_level_calibrator.sv
// Directed bench for level_calibrator: conversion table plus hand-written calibration/abort sequences.
module tb_level_calibrator;

  localparam int W = 12;
`ifdef LEVEL_CAL_AVG_EN
  localparam int NCAP = 8;
  localparam int EXP_AVG_LOW = 103;
`else
  localparam int NCAP = 1;
  localparam int EXP_AVG_LOW = 100;
`endif

  typedef struct {
    int sample;
    int expPct;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nCmp = 0;
  int   nFail = 0;

  always #5 clk = ~clk;

  level_calibrator_if #(.W(W)) bus ();

  level_calibrator #(.W(W), .MIN_SPAN(16), .AVG_LOG2(3)) dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .bus        (bus)
  );

  task automatic check(input string nm, input int act, input int exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic pulse(input bit r, input bit h, input bit l);
    @(negedge clk);
    bus.reset_button_out = r;
    bus.saveH_button_out = h;
    bus.saveL_button_out = l;
    @(negedge clk);
    bus.reset_button_out = 1'b0;
    bus.saveH_button_out = 1'b0;
    bus.saveL_button_out = 1'b0;
  endtask

  task automatic sendSample(input int v);
    @(negedge clk);
    bus.sample       = v[W-1:0];
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic waitIdle(input string nm);
    int n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(nm, int'(bus.busy), 0);
  endtask

  task automatic capture(input bit high, input int v);
    pulse(1'b0, high, !high);
    for (int i = 0; i < NCAP; i++) sendSample(v);
    waitIdle("capture_idle");
  endtask

  // Returns cycle index of level_valid relative to the sample_valid cycle (-1 if none).
  task automatic runConv(input int v, output int lat, output int pct, output int busyOk);
    int n;
    sendSample(v);
    n = 1;
    busyOk = 1;
    while (!bus.level_valid && n < 40) begin
      if (!bus.busy) busyOk = 0;
      @(negedge clk);
      n++;
    end
    if (!bus.busy) busyOk = 0;
    lat = bus.level_valid ? n : -1;
    pct = int'(bus.level_pct);
  endtask

  task automatic countValid(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.level_valid) seen++;
    end
  endtask

  initial begin
    vec_t tbl[7];
    int lat, pct, busyOk, seen, lastPct;

    bus.sample_valid     = 1'b0;
    bus.sample           = '0;
    bus.reset_button_out = 1'b0;
    bus.saveH_button_out = 1'b0;
    bus.saveL_button_out = 1'b0;

    tbl[0] = '{2048, 50};
    tbl[1] = '{2000, 50};
    tbl[2] = '{500,  0};
    tbl[3] = '{3500, 100};
    tbl[4] = '{2999, 99};
    tbl[5] = '{1000, 0};
    tbl[6] = '{3000, 100};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_level_pct",   int'(bus.level_pct),   0);
    check("rst_level_valid", int'(bus.level_valid), 0);
    check("rst_cal_low",     int'(bus.cal_low),     0);
    check("rst_cal_high",    int'(bus.cal_high),    4095);
    check("rst_cal_ok",      int'(bus.cal_ok),      1);
    check("rst_busy",        int'(bus.busy),        0);

    // Default calibration conversion
    runConv(tbl[0].sample, lat, pct, busyOk);
    check("t1_pct", pct, tbl[0].expPct);
    check("t1_latency", lat, 21);
    check("t1_busy_window", busyOk, 1);
    @(negedge clk);
    check("t1_valid_one_cycle", int'(bus.level_valid), 0);
    check("t1_busy_after", int'(bus.busy), 0);

    capture(1'b0, 1000);
    capture(1'b1, 3000);
    check("t2_cal_low",  int'(bus.cal_low),  1000);
    check("t2_cal_high", int'(bus.cal_high), 3000);
    check("t2_cal_ok",   int'(bus.cal_ok),   1);

    for (int i = 1; i < 7; i++) begin
      runConv(tbl[i].sample, lat, pct, busyOk);
      check($sformatf("t2_pct[%0d]", tbl[i].sample), pct, tbl[i].expPct);
      check($sformatf("t2_lat[%0d]", tbl[i].sample), lat, 21);
    end
    lastPct = tbl[6].expPct;

    // Span too small: calibration invalid, samples ignored
    capture(1'b1, 1010);
    check("t3_cal_high", int'(bus.cal_high), 1010);
    check("t3_cal_ok",   int'(bus.cal_ok),   0);
    sendSample(2000);
    countValid(30, seen);
    check("t3_no_valid", seen, 0);
    check("t3_pct_held", int'(bus.level_pct), lastPct);
    pulse(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("t3_rst_cal_ok",   int'(bus.cal_ok),   1);
    check("t3_rst_cal_high", int'(bus.cal_high), 4095);
    check("t3_rst_cal_low",  int'(bus.cal_low),  0);

    // Button held for several cycles must count once
    @(negedge clk);
    bus.saveL_button_out = 1'b1;
    repeat (5) @(negedge clk);
    bus.saveL_button_out = 1'b0;
    for (int i = 0; i < NCAP; i++) sendSample(1200);
    repeat (10) @(negedge clk);
    check("hold_once_busy", int'(bus.busy), 0);
    check("hold_cal_low", int'(bus.cal_low), 1200);

    // Simultaneous saveH + saveL: high first, then low
    pulse(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < NCAP; i++) sendSample(3000);
    repeat (4) @(negedge clk);
    for (int i = 0; i < NCAP; i++) sendSample(1000);
    waitIdle("t4_idle");
    check("t4_cal_high", int'(bus.cal_high), 3000);
    check("t4_cal_low",  int'(bus.cal_low),  1000);

    // saveH during DIV is served after DONE
    sendSample(2000);
    repeat (5) @(negedge clk);
    pulse(1'b0, 1'b1, 1'b0);
    seen = 0;
    for (int i = 0; i < 40 && !bus.level_valid; i++) @(negedge clk);
    check("t4_div_valid", int'(bus.level_valid), 1);
    check("t4_div_pct",   int'(bus.level_pct),   50);
    @(negedge clk);
    check("t4_idle_after_done", int'(bus.busy), 0);
    @(negedge clk);
    check("t4_pending_capture", int'(bus.busy), 1);
    for (int i = 0; i < NCAP; i++) sendSample(2500);
    waitIdle("t4_cap_idle");
    check("t4_pend_cal_high", int'(bus.cal_high), 2500);
    check("t4_pend_cal_ok",   int'(bus.cal_ok),   1);

    // reset_button mid-DIV aborts with no level_valid
    sendSample(2000);
    repeat (6) @(negedge clk);
    check("t5_in_div", int'(bus.busy), 1);
    pulse(1'b1, 1'b0, 1'b0);
    check("t5_idle_next", int'(bus.busy), 0);
    countValid(30, seen);
    check("t5_no_valid", seen, 0);
    check("t5_cal_low",  int'(bus.cal_low),  0);
    check("t5_cal_high", int'(bus.cal_high), 4095);
    check("t5_cal_ok",   int'(bus.cal_ok),   1);
    check("t5_pct_kept", int'(bus.level_pct), 50);

    // Async reset mid-CAPTURE
    pulse(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("t5_in_capture", int'(bus.busy), 1);
    #2 reset = 1'b1;
    #1;
    check("t5_ar_level_pct",   int'(bus.level_pct),   0);
    check("t5_ar_level_valid", int'(bus.level_valid), 0);
    check("t5_ar_cal_low",     int'(bus.cal_low),     0);
    check("t5_ar_cal_high",    int'(bus.cal_high),    4095);
    check("t5_ar_cal_ok",      int'(bus.cal_ok),      1);
    check("t5_ar_busy",        int'(bus.busy),        0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Averaged vs single-sample capture
    pulse(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) sendSample(100 + i);
    waitIdle("t6_idle");
    check("t6_cal_low", int'(bus.cal_low), EXP_AVG_LOW);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
